// File: rtl/binseq_pkg.sv
// Shared types and width helpers for the binarize sequencer slice.
package binseq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    EMIT = 2'd3
  } state_t;

  // Cycles a done flag is masked after start, so a stale done cannot qualify.
  function automatic int qual_lat(input int levels);
    return levels + 1;
  endfunction

  function automatic int cnt_w(input int pack);
    return $clog2(pack) + 1;
  endfunction

  function automatic int run_w(input int timeout, input int levels);
    return $clog2(timeout + levels + 3);
  endfunction

endpackage

// File: rtl/binseq_packer.sv
// Pack buffer: writes LEVELS-bit results into successive slots and holds the word
// plus its fill count until cleared; cleared slots read back as 0.
module binseq_packer
  import binseq_pkg::*;
#(
  parameter int LEVELS = 2,
  parameter int PACK   = 8,
  parameter int CW     = cnt_w(PACK)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [LEVELS-1:0]      wr_bits,
  input  logic                   clr,
  output logic [CW-1:0]          cnt,
  output logic [PACK*LEVELS-1:0] bits
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      bits <= '0;
    end else if (clr) begin
      cnt  <= '0;
      bits <= '0;
    end else if (wr) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt == CW'(i)) bits[i*LEVELS +: LEVELS] <= wr_bits;
      end
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/binarize_sequencer.sv
// Sequences the residual binarizer per pixel, owns the gamma bank and packs results.
// Optional done watchdog enabled by defining BINSEQ_WDOG_EN.
module binarize_sequencer
  import binseq_pkg::*;
#(
  parameter int TWIDTH  = 24,
  parameter int LEVELS  = 2,
  parameter int PACK    = 8,
  parameter int LVL_AW  = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  // Streams use valid/ready: a transfer happens on a rising edge where both are 1;
  // the producer holds data stable while valid=1 and ready=0.
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TWIDTH-1:0]        in_pixel,
  input  logic                     cfg_we,
  input  logic [LVL_AW-1:0]        cfg_addr,
  input  logic [TWIDTH-1:0]        cfg_wdata,
  input  logic                     flush,
  output logic                     dp_start,
  output logic [TWIDTH-1:0]        dp_pixel,
  output logic [TWIDTH*LEVELS-1:0] dp_gamma,
  input  logic                     dp_done,
  input  logic [LEVELS-1:0]        dp_bits,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PACK*LEVELS-1:0]   out_bits,
  output logic [cnt_w(PACK)-1:0]   out_count,
  output logic                     busy,
  output logic                     err,
  output logic [1:0]               dbg_state
);

  localparam int QL = qual_lat(LEVELS);
  localparam int RW = run_w(TIMEOUT, LEVELS);
  localparam int CW = cnt_w(PACK);

  state_t              state, state_nx;
  logic [RW-1:0]       run_cnt;
  logic [CW-1:0]       pack_cnt;
  logic                qual, timeout, flush_go, accept, wdog_q;
  logic [TWIDTH-1:0]   gamma [LEVELS];
  logic [LEVELS-1:0]   slot_bits;

  assign qual     = (state == RUN) && dp_done && (run_cnt >= RW'(QL - 1));
  assign flush_go = (state == IDLE) && flush && (pack_cnt != '0);
  assign accept   = in_valid && in_ready;

`ifdef BINSEQ_WDOG_EN
  // run_cnt holds completed RUN cycles, so this fires on RUN cycle TIMEOUT+1.
  assign timeout = (state == RUN) && !qual && (run_cnt >= RW'(TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (flush_go) state_nx = EMIT;
            else if (accept) state_nx = RUN;
      RUN:  if (qual || timeout) state_nx = CAPT;
      CAPT: state_nx = (pack_cnt == CW'(PACK - 1)) ? EMIT : IDLE;
      EMIT: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // in_ready is forced low while reset is held so every output reads 0 in reset.
  always_comb begin
    dp_start  = (state == RUN);
    out_valid = (state == EMIT);
    in_ready  = rst && (state == IDLE) && !flush_go;
    busy      = (state != IDLE) || (pack_cnt != '0);
    dbg_state = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt  <= '0;
      wdog_q   <= 1'b0;
      dp_pixel <= '0;
      err      <= 1'b0;
      for (int k = 0; k < LEVELS; k++) gamma[k] <= '0;
    end else begin
      if (state == RUN) begin
        if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
      end else begin
        run_cnt <= '0;
      end
      wdog_q <= timeout;
      if (accept) dp_pixel <= in_pixel;
      if ((cfg_we && busy) || timeout) err <= 1'b1;
      for (int k = 0; k < LEVELS; k++) begin
        if (cfg_we && !busy && (cfg_addr == LVL_AW'(k))) gamma[k] <= cfg_wdata;
      end
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_gamma
    assign dp_gamma[k*TWIDTH +: TWIDTH] = gamma[k];
  end

  assign slot_bits = wdog_q ? '0 : dp_bits;

  binseq_packer #(
    .LEVELS (LEVELS),
    .PACK   (PACK),
    .CW     (CW)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .wr      (state == CAPT),
    .wr_bits (slot_bits),
    .clr     (out_valid && out_ready),
    .cnt     (pack_cnt),
    .bits    (out_bits)
  );

  assign out_count = pack_cnt;

endmodule

// File: tb/tb_binarize_sequencer.sv
// Directed bench for binarize_sequencer with a queue-based pack model and per-cycle checks.
module tb_binarize_sequencer;

  localparam int TW = 24;
  localparam int LV = 2;
  localparam int PK = 8;
  localparam int QL = LV + 1;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_pixel = '0;
  logic          cfg_we = 1'b0;
  logic [0:0]    cfg_addr = '0;
  logic [TW-1:0] cfg_wdata = '0;
  logic          flush = 1'b0;
  logic          dp_start;
  logic [TW-1:0] dp_pixel;
  logic [47:0]   dp_gamma;
  logic          dp_done = 1'b0;
  logic [1:0]    dp_bits = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [15:0]   out_bits;
  logic [3:0]    out_count;
  logic          busy;
  logic          err;
  logic [1:0]    dbg_state;

  binarize_sequencer #(
    .TWIDTH(TW), .LEVELS(LV), .PACK(PK), .LVL_AW(1), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .flush(flush),
    .dp_start(dp_start), .dp_pixel(dp_pixel), .dp_gamma(dp_gamma), .dp_done(dp_done),
    .dp_bits(dp_bits), .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_count(out_count), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // model state
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  cnt_q[$];
  logic [1:0]  pend[$];
  logic [TW-1:0] g_model[LV];
  logic        exp_err = 1'b0;
  logic        chk_en = 1'b0;
  logic [1:0]  cur_bits;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic emit_model();
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < pend.size(); i++) w[i*2 +: 2] = pend[i];
    exp_q.push_back(w);
    cnt_q.push_back(4'(pend.size()));
    pend.delete();
  endtask

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    cnt_q.delete();
    for (int k = 0; k < LV; k++) g_model[k] = '0;
    exp_err = 1'b0;
  endtask

  // scoreboard: compared on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("dp_gamma", 64'(dp_gamma), 64'({g_model[1], g_model[0]}));
      check("err", 64'(err), 64'(exp_err));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(out_valid), 64'd0);
        end else begin
          check("out_bits", 64'(out_bits), 64'(exp_q[0]));
          check("out_count", 64'(out_count), 64'(cnt_q[0]));
          check("in_ready_in_emit", 64'(in_ready), 64'd0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(cnt_q.pop_front());
          end
        end
      end
    end
  end

  // driver tasks
  task automatic cfg_write(input logic addr, input logic [TW-1:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    g_model[addr] = data;
  endtask

  task automatic accept_pixel(input logic [TW-1:0] pix, input logic [1:0] bits, input logic done0);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_pixel = pix; dp_bits = bits; dp_done = done0; cur_bits = bits;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("dp_pixel", 64'(dp_pixel), 64'(pix));
  endtask

  // lat: RUN cycle (1-based) at which dp_done rises; 0 means already high at start
  task automatic run_to_capt(input int lat, input bit poke);
    int cyc, exp_len;
    bit to;
    cyc = 0;
    exp_len = (lat > QL) ? lat : QL;
`ifdef BINSEQ_WDOG_EN
    if (exp_len > TO + 1) exp_len = TO + 1;
    to = (exp_len == TO + 1) && (lat > TO + 1);
`else
    to = 1'b0;
`endif
    while (dp_start === 1'b1 && cyc < 300) begin
      cyc++;
      if (cyc >= lat) dp_done = 1'b1;
      if (poke && cyc == 1) begin cfg_we = 1'b1; cfg_addr = 1'b0; cfg_wdata = 24'hABCDEF; end
      @(posedge clk); #1;
      if (poke && cyc == 1) begin cfg_we = 1'b0; exp_err = 1'b1; end
    end
    check("run_len", 64'(cyc), 64'(exp_len));
    if (to) exp_err = 1'b1;
    @(posedge clk); #1;
    pend.push_back(to ? 2'b00 : cur_bits);
    if (pend.size() == PK) emit_model();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    if (pend.size() > 0) emit_model();
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  int lat_t[8] = '{0, 4, 0, 2, 6, 0, 3, 5};
  logic [1:0] b5[8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dp_gamma", 64'(dp_gamma), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // gamma load, then a write while busy
    cfg_write(1'b0, 24'h000100);
    cfg_write(1'b1, 24'h000080);
    check("gamma_pin", 64'(dp_gamma), 64'h000080_000100);

    // eight pixels, alternating results; first one with done held from start
    for (int i = 0; i < PK; i++) begin
      if (i == PK - 1) out_ready = 1'b0;
      accept_pixel(24'h000100 + 24'(i), i[0] ? 2'b10 : 2'b01, lat_t[i] == 0);
      if (i > 0) dp_done = (lat_t[i] == 0);
      run_to_capt(lat_t[i], i == 0);
      if (i == 0) begin
        check("busy_write_err", 64'(err), 64'd1);
        check("busy_write_bank", 64'(dp_gamma), 64'h000080_000100);
      end
    end
    check("pack_pin_bits", 64'(out_bits), 64'h9999);
    check("pack_pin_count", 64'(out_count), 64'd8);
    repeat (5) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);

    // partial pack flushed, then flush of an empty buffer
    accept_pixel(24'h000200, 2'b11, 1'b1); run_to_capt(0, 1'b0);
    accept_pixel(24'h000201, 2'b01, 1'b0); run_to_capt(2, 1'b0);
    accept_pixel(24'h000202, 2'b10, 1'b1); run_to_capt(0, 1'b0);
    check("partial_busy", 64'(busy), 64'd1);
    do_flush();
    check("flush_valid", 64'(out_valid), 64'd1);
    check("flush_pin_bits", 64'(out_bits), 64'h0027);
    check("flush_pin_count", 64'(out_count), 64'd3);
    check("flush_unused_zero", 64'(out_bits[15:6]), 64'd0);
    @(posedge clk); #1;
    check("flush_drained", 64'(out_valid), 64'd0);
    do_flush();
    repeat (3) begin
      check("empty_flush_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end

    // reset in the middle of the fifth pixel
    for (int i = 0; i < 4; i++) begin
      accept_pixel(24'h000300 + 24'(i), 2'b10, 1'b1);
      run_to_capt(0, 1'b0);
    end
    accept_pixel(24'h000304, 2'b11, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_start", 64'(dp_start), 64'd1);
    #2;
    rst = 1'b0; in_valid = 1'b0; dp_done = 1'b0;
    model_reset();
    #1;
    check("mid_rst_dp_start", 64'(dp_start), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_dp_pixel", 64'(dp_pixel), 64'd0);
    check("mid_rst_dp_gamma", 64'(dp_gamma), 64'd0);
    check("mid_rst_out_bits", 64'(out_bits), 64'd0);
    check("mid_rst_out_count", 64'(out_count), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < PK; i++) begin
      accept_pixel(24'h000400 + 24'(i), b5[i], (i % 3) != 1);
      run_to_capt(((i % 3) != 1) ? 0 : 4, 1'b0);
    end
    check("post_rst_pin_bits", 64'(out_bits), 64'h1BE4);
    check("post_rst_pin_count", 64'(out_count), 64'd8);
    @(posedge clk); #1;

`ifdef BINSEQ_WDOG_EN
    // done never arrives: watchdog closes the slot with zero bits
    accept_pixel(24'h000500, 2'b11, 1'b0);
    run_to_capt(1000, 1'b0);
    check("wdog_err", 64'(err), 64'd1);
    do_flush();
    check("wdog_slot_bits", 64'(out_bits), 64'h0000);
    check("wdog_slot_count", 64'(out_count), 64'd1);
    @(posedge clk); #1;
`endif

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
